// File: rtl/spi_master_datapath.sv
// SPI master datapath (mode 0: MSB first, sample on rising SCLK, shift on falling SCLK).
// Holds the packet-size and chip-select address registers, the TX/RX shift registers and
// the bit counter, all sequenced by strobes from the companion control FSM.
//
// Ports:
//   clk, reset_n         - clock, asynchronous active-low reset
//   recv_msg             - word to transmit, right-aligned
//   packet_size_in/_en   - packet size (bits) and its capture enable
//   cs_addr_in/_en       - target peripheral index and its capture enable
//   shreg_load           - start a packet: load TX, clear RX, load counter
//   sclk_posedge/negedge - one-cycle SCLK edge strobes
//   cs_level             - active-low chip-select level from the FSM
//   spi_miso / spi_mosi  - serial in / serial out
//   cs_n                 - per-peripheral active-low chip selects
//   send_msg             - received word, right-aligned
//   packet_size_reg      - registered (unclamped) packet size
//   cs_addr_reg          - registered peripheral index
//   bit_cnt_zero         - bit counter is zero
module spi_master_datapath #(
  parameter int unsigned nbits   = 32,
  parameter int unsigned ncs     = 1,
  parameter int unsigned logncs  = (ncs > 1) ? $clog2(ncs) : 1,
  parameter int unsigned logbits = $clog2(nbits) + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [nbits-1:0]   recv_msg,
  input  logic [logbits-1:0] packet_size_in,
  input  logic               packet_size_reg_en,
  input  logic [logncs-1:0]  cs_addr_in,
  input  logic               cs_addr_reg_en,
  input  logic               shreg_load,
  input  logic               sclk_posedge,
  input  logic               sclk_negedge,
  input  logic               cs_level,
  input  logic               spi_miso,
  output logic               spi_mosi,
  output logic [ncs-1:0]     cs_n,
  output logic [nbits-1:0]   send_msg,
  output logic [logbits-1:0] packet_size_reg,
  output logic [logncs-1:0]  cs_addr_reg,
  output logic               bit_cnt_zero
);

  localparam logic [logbits-1:0] NbitsW = logbits'(nbits);

  logic [logbits-1:0] size_q;
  logic [logncs-1:0]  cs_addr_q;
  logic [nbits-1:0]   tx_q;
  logic [nbits-1:0]   rx_q;
  logic [logbits-1:0] cnt_q;

  logic [logbits-1:0] size_sel;
  logic [logbits-1:0] eff_size;
  logic [nbits-1:0]   tx_load;

  // A size written in the same cycle as the load takes effect immediately.
  always_comb begin
    size_sel = packet_size_reg_en ? packet_size_in : size_q;
    eff_size = (size_sel > NbitsW) ? NbitsW : size_sel;
    // Left-justify so bit eff_size-1 sits at the MSB; a shift of nbits (size 0) yields 0.
    tx_load  = recv_msg << (NbitsW - eff_size);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      size_q    <= '0;
      cs_addr_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      cnt_q     <= '0;
    end else begin
      if (packet_size_reg_en) size_q <= packet_size_in;
      if (cs_addr_reg_en)     cs_addr_q <= cs_addr_in;

      if (shreg_load) begin
        tx_q  <= tx_load;
        rx_q  <= '0;
        cnt_q <= eff_size;
      end else begin
        // Posedges past the end of the packet are ignored so the counter never wraps.
        if (sclk_posedge && (cnt_q != '0)) begin
          rx_q  <= {rx_q[nbits-2:0], spi_miso};
          cnt_q <= cnt_q - logbits'(1);
        end
        if (sclk_negedge) begin
          tx_q <= {tx_q[nbits-2:0], 1'b0};
        end
      end
    end
  end

  // Gated by reset so all selects deassert asynchronously, regardless of cs_level.
  always_comb begin
    cs_n = '1;
    if (reset_n) begin
      for (int i = 0; i < int'(ncs); i++) begin
        if (cs_addr_q == logncs'(i)) cs_n[i] = cs_level;
      end
    end
  end

  assign spi_mosi        = tx_q[nbits-1];
  assign send_msg        = rx_q;
  assign packet_size_reg = size_q;
  assign cs_addr_reg     = cs_addr_q;
  assign bit_cnt_zero    = (cnt_q == '0);

endmodule

// File: tb/tb_spi_master_datapath.sv
module tb_spi_master_datapath;

  localparam int unsigned NBITS = 8;
  localparam int unsigned NCS   = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] recv_msg;
  logic [3:0] packet_size_in;
  logic       packet_size_reg_en;
  logic [1:0] cs_addr_in;
  logic       cs_addr_reg_en;
  logic       shreg_load;
  logic       sclk_posedge;
  logic       sclk_negedge;
  logic       cs_level;
  logic       spi_miso;
  logic       spi_mosi;
  logic [3:0] cs_n;
  logic [7:0] send_msg;
  logic [3:0] packet_size_reg;
  logic [1:0] cs_addr_reg;
  logic       bit_cnt_zero;

  logic loop_en;
  logic miso_drv;

  int checks = 0;
  int errors = 0;

  assign spi_miso = loop_en ? spi_mosi : miso_drv;

  always #5 clk = ~clk;

  spi_master_datapath #(
    .nbits(NBITS),
    .ncs  (NCS)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .recv_msg          (recv_msg),
    .packet_size_in    (packet_size_in),
    .packet_size_reg_en(packet_size_reg_en),
    .cs_addr_in        (cs_addr_in),
    .cs_addr_reg_en    (cs_addr_reg_en),
    .shreg_load        (shreg_load),
    .sclk_posedge      (sclk_posedge),
    .sclk_negedge      (sclk_negedge),
    .cs_level          (cs_level),
    .spi_miso          (spi_miso),
    .spi_mosi          (spi_mosi),
    .cs_n              (cs_n),
    .send_msg          (send_msg),
    .packet_size_reg   (packet_size_reg),
    .cs_addr_reg       (cs_addr_reg),
    .bit_cnt_zero      (bit_cnt_zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] msg, input logic [3:0] size);
    recv_msg           = msg;
    packet_size_in     = size;
    packet_size_reg_en = 1'b1;
    shreg_load         = 1'b1;
    tick();
    packet_size_reg_en = 1'b0;
    shreg_load         = 1'b0;
  endtask

  task automatic do_pos();
    sclk_posedge = 1'b1;
    tick();
    sclk_posedge = 1'b0;
  endtask

  task automatic do_neg();
    sclk_negedge = 1'b1;
    tick();
    sclk_negedge = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (spi_mosi !== 1'b0) begin
      errors++; $display("FAIL reset_mosi got %b want 0", spi_mosi);
    end
    checks++;
    if (cs_n !== 4'b1111) begin
      errors++; $display("FAIL reset_cs_n got %b want 1111", cs_n);
    end
    checks++;
    if (send_msg !== 8'h00) begin
      errors++; $display("FAIL reset_send_msg got %h want 00", send_msg);
    end
    checks++;
    if (bit_cnt_zero !== 1'b1) begin
      errors++; $display("FAIL reset_bcz got %b want 1", bit_cnt_zero);
    end
    checks++;
    if (packet_size_reg !== 4'd0 || cs_addr_reg !== 2'd0) begin
      errors++;
      $display("FAIL reset_regs got size=%0d addr=%0d want 0/0", packet_size_reg, cs_addr_reg);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_full_byte();
    logic [7:0] exp;
    exp     = 8'hA5;
    loop_en = 1'b1;
    do_load(exp, 4'd8);
    checks++;
    if (packet_size_reg !== 4'd8) begin
      errors++; $display("FAIL full_size_reg got %0d want 8", packet_size_reg);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (spi_mosi !== exp[7-i]) begin
        errors++; $display("FAIL full_mosi bit %0d got %b want %b", i, spi_mosi, exp[7-i]);
      end
      do_pos();
      if (i == 6) begin
        checks++;
        if (bit_cnt_zero !== 1'b0) begin
          errors++; $display("FAIL full_bcz_early got %b want 0", bit_cnt_zero);
        end
      end
      if (i == 7) begin
        checks++;
        if (bit_cnt_zero !== 1'b1) begin
          errors++; $display("FAIL full_bcz_done got %b want 1", bit_cnt_zero);
        end
        checks++;
        if (send_msg !== 8'hA5) begin
          errors++; $display("FAIL full_send_msg got %h want a5", send_msg);
        end
      end
      do_neg();
    end
  endtask

  task automatic test_short();
    logic [3:0] mosi_exp;
    logic [3:0] miso_pat;
    mosi_exp = 4'b1100;
    miso_pat = 4'b1001;
    loop_en  = 1'b0;
    do_load(8'h0C, 4'd4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (spi_mosi !== mosi_exp[3-i]) begin
        errors++; $display("FAIL short_mosi bit %0d got %b want %b", i, spi_mosi, mosi_exp[3-i]);
      end
      miso_drv = miso_pat[3-i];
      do_pos();
      do_neg();
    end
    checks++;
    if (send_msg !== 8'h09 || bit_cnt_zero !== 1'b1) begin
      errors++;
      $display("FAIL short_done got send=%h bcz=%b want 09/1", send_msg, bit_cnt_zero);
    end
    miso_drv = 1'b1;
    do_pos();
    checks++;
    if (send_msg !== 8'h09 || bit_cnt_zero !== 1'b1) begin
      errors++;
      $display("FAIL short_extra_pos got send=%h bcz=%b want 09/1", send_msg, bit_cnt_zero);
    end
  endtask

  task automatic test_clamp();
    loop_en = 1'b1;
    do_load(8'h81, 4'd12);
    checks++;
    if (packet_size_reg !== 4'd12) begin
      errors++; $display("FAIL clamp_size_reg got %0d want 12", packet_size_reg);
    end
    for (int i = 0; i < 8; i++) begin
      do_pos();
      if (i == 6) begin
        checks++;
        if (bit_cnt_zero !== 1'b0) begin
          errors++; $display("FAIL clamp_bcz_7 got %b want 0", bit_cnt_zero);
        end
      end
      do_neg();
    end
    checks++;
    if (send_msg !== 8'h81 || bit_cnt_zero !== 1'b1) begin
      errors++;
      $display("FAIL clamp_done got send=%h bcz=%b want 81/1", send_msg, bit_cnt_zero);
    end
    do_load(8'hFF, 4'd0);
    checks++;
    if (bit_cnt_zero !== 1'b1 || spi_mosi !== 1'b0 || send_msg !== 8'h00) begin
      errors++;
      $display("FAIL size0_load got bcz=%b mosi=%b send=%h want 1/0/00",
               bit_cnt_zero, spi_mosi, send_msg);
    end
    loop_en  = 1'b0;
    miso_drv = 1'b1;
    do_pos();
    checks++;
    if (send_msg !== 8'h00) begin
      errors++; $display("FAIL size0_pos got send=%h want 00", send_msg);
    end
  endtask

  task automatic test_cs();
    cs_level       = 1'b0;
    cs_addr_in     = 2'd2;
    cs_addr_reg_en = 1'b1;
    tick();
    cs_addr_reg_en = 1'b0;
    checks++;
    if (cs_addr_reg !== 2'd2 || cs_n !== 4'b1011) begin
      errors++; $display("FAIL cs_sel2 got addr=%0d cs_n=%b want 2/1011", cs_addr_reg, cs_n);
    end
    cs_level = 1'b1;
    #1;
    checks++;
    if (cs_n !== 4'b1111) begin
      errors++; $display("FAIL cs_level_hi got %b want 1111", cs_n);
    end
    cs_addr_in     = 2'd3;
    cs_addr_reg_en = 1'b1;
    tick();
    cs_addr_reg_en = 1'b0;
    checks++;
    if (cs_n !== 4'b1111) begin
      errors++; $display("FAIL cs_change_hi got %b want 1111", cs_n);
    end
    cs_level = 1'b0;
    #1;
    checks++;
    if (cs_n !== 4'b0111) begin
      errors++; $display("FAIL cs_sel3 got %b want 0111", cs_n);
    end
    cs_level = 1'b1;
  endtask

  task automatic test_load_wins();
    loop_en  = 1'b0;
    miso_drv = 1'b1;
    do_load(8'h00, 4'd3);
    do_pos();
    checks++;
    if (send_msg !== 8'h01) begin
      errors++; $display("FAIL lw_pre got send=%h want 01", send_msg);
    end
    sclk_posedge = 1'b1;
    do_load(8'h00, 4'd5);
    sclk_posedge = 1'b0;
    checks++;
    if (send_msg !== 8'h00 || bit_cnt_zero !== 1'b0) begin
      errors++;
      $display("FAIL lw_load got send=%h bcz=%b want 00/0", send_msg, bit_cnt_zero);
    end
    for (int i = 0; i < 4; i++) do_pos();
    checks++;
    if (bit_cnt_zero !== 1'b0) begin
      errors++; $display("FAIL lw_cnt4 got bcz=%b want 0", bit_cnt_zero);
    end
    do_pos();
    checks++;
    if (send_msg !== 8'h1F || bit_cnt_zero !== 1'b1) begin
      errors++;
      $display("FAIL lw_done got send=%h bcz=%b want 1f/1", send_msg, bit_cnt_zero);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    cs_addr_in     = 2'd0;
    cs_addr_reg_en = 1'b1;
    tick();
    cs_addr_reg_en = 1'b0;
    cs_level = 1'b0;
    loop_en  = 1'b1;
    do_load(8'hF0, 4'd8);
    for (int i = 0; i < 3; i++) begin
      do_pos();
      do_neg();
    end
    checks++;
    if (send_msg !== 8'h07 || spi_mosi !== 1'b1 || cs_n !== 4'b1110) begin
      errors++;
      $display("FAIL mid_pre got send=%h mosi=%b cs_n=%b want 07/1/1110",
               send_msg, spi_mosi, cs_n);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (spi_mosi !== 1'b0 || cs_n !== 4'b1111 || send_msg !== 8'h00 || bit_cnt_zero !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got mosi=%b cs_n=%b send=%h bcz=%b want 0/1111/00/1",
               spi_mosi, cs_n, send_msg, bit_cnt_zero);
    end
    tick();
    reset_n = 1'b1;
    tick();
    exp = 8'h3C;
    do_load(exp, 4'd8);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (spi_mosi !== exp[7-i]) begin
        errors++; $display("FAIL post_mosi bit %0d got %b want %b", i, spi_mosi, exp[7-i]);
      end
      do_pos();
      do_neg();
    end
    checks++;
    if (send_msg !== 8'h3C || bit_cnt_zero !== 1'b1) begin
      errors++;
      $display("FAIL post_done got send=%h bcz=%b want 3c/1", send_msg, bit_cnt_zero);
    end
  endtask

  initial begin
    reset_n            = 1'b0;
    recv_msg           = '0;
    packet_size_in     = '0;
    packet_size_reg_en = 1'b0;
    cs_addr_in         = '0;
    cs_addr_reg_en     = 1'b0;
    shreg_load         = 1'b0;
    sclk_posedge       = 1'b0;
    sclk_negedge       = 1'b0;
    cs_level           = 1'b0;
    loop_en            = 1'b0;
    miso_drv           = 1'b0;

    test_reset();
    test_full_byte();
    test_short();
    test_clamp();
    test_cs();
    test_load_wins();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
